fuzz_harness_sched: RTL and testbench

Next-generation stimulus harness placed between N stimulus sources and one DUT (e.g. aes_128).
- Source 0 is the system bus; sources 1..NUM_SRC-1 are fuzzers.
- Replaces the fixed 3-way combinational mux with a scheduled, transaction-aware switch. Supports manual and auto-rotate modes.
- Adds a one-outstanding-transaction tracker, a harness watchdog and sticky first-error capture.

---
 rtl/fuzz_harness_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_fuzz_harness_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_harness_sched.sv
// Scheduled stimulus switch between NUM_SRC sources and one DUT: one outstanding
// transaction, manual or epoch-based round-robin selection, watchdog and first-error capture.
module fuzz_harness_sched #(
  parameter int unsigned INPUT_WIDTH    = 256,
  parameter int unsigned OUTPUT_WIDTH   = 128,
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned EPOCH_LEN      = 64,
  parameter int unsigned WATCHDOG_LIMIT = 1000,
  parameter int unsigned SEL_W          = $clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           auto_mode,
  input  logic [SEL_W-1:0]               sel_req,
  input  logic                           err_clr,
  input  logic [NUM_SRC*INPUT_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]             src_start,
  input  logic [NUM_SRC-1:0]             src_col,
  input  logic [NUM_SRC*8-1:0]           src_cov,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic [NUM_SRC-1:0]             src_valid,
  output logic [INPUT_WIDTH-1:0]         dut_data,
  output logic                           dut_start,
  input  logic                           dut_ready,
  input  logic [OUTPUT_WIDTH-1:0]        dut_out,
  input  logic                           dut_out_valid,
  output logic [OUTPUT_WIDTH-1:0]        res_data,
  output logic [SEL_W-1:0]               active_sel,
  output logic                           alarm_hang,
  output logic                           alarm_collision,
  output logic [7:0]                     coverage_score,
  output logic [31:0]                    txn_count,
  output logic                           err_valid,
  output logic [INPUT_WIDTH-1:0]         error_input,
  output logic [OUTPUT_WIDTH-1:0]        error_output
);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain, StSwitch} state_e;

  localparam logic [SEL_W:0]   NumSrcW  = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] LastSel  = SEL_W'(NUM_SRC - 1);
  localparam logic [31:0]      WdLast   = 32'(WATCHDOG_LIMIT - 1);
  localparam logic [31:0]      EpochLen = 32'(EPOCH_LEN);

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        active_sel_q, active_sel_d;
  logic                    sw_auto_q, sw_auto_d;
  logic [SEL_W-1:0]        sw_sel_q, sw_sel_d;
  logic [INPUT_WIDTH-1:0]  dut_data_q, dut_data_d;
  logic                    dut_start_q, dut_start_d;
  logic [31:0]             wd_cnt_q, wd_cnt_d;
  logic [31:0]             epoch_cnt_q, epoch_cnt_d;
  logic [31:0]             txn_count_q, txn_count_d;
  logic                    alarm_hang_q, alarm_hang_d;
  logic                    err_valid_q, err_valid_d;
  logic [INPUT_WIDTH-1:0]  error_input_q, error_input_d;
  logic [OUTPUT_WIDTH-1:0] error_output_q, error_output_d;

  logic [NUM_SRC-1:0]     act_onehot;
  logic [INPUT_WIDTH-1:0] sel_data;
  logic [7:0]             sel_cov;
  logic                   sel_col;
  logic                   sel_start;

  always_comb begin
    act_onehot = '0;
    sel_data   = '0;
    sel_cov    = '0;
    sel_col    = 1'b0;
    sel_start  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (active_sel_q == SEL_W'(k)) begin
        act_onehot[k] = 1'b1;
        sel_data      = src_data[k*INPUT_WIDTH +: INPUT_WIDTH];
        sel_cov       = src_cov[k*8 +: 8];
        sel_col       = src_col[k];
        sel_start     = src_start[k];
      end
    end
  end

  logic        manual_req, idle_auto_req, idle_sw, idle_ok;
  logic        in_txn, done, abort, auto_roll, err_trig;
  logic [31:0] epoch_next;

  always_comb begin
    manual_req    = !auto_mode && ({1'b0, sel_req} < NumSrcW) && (sel_req != active_sel_q);
    // Catches a manual-to-auto change after the epoch counter already ran past the limit.
    idle_auto_req = auto_mode && (epoch_cnt_q >= EpochLen);
    idle_sw       = manual_req || idle_auto_req;
    idle_ok       = (state_q == StIdle) && dut_ready && !idle_sw;
    in_txn        = (state_q == StBusy) || (state_q == StDrain);
    done          = in_txn && dut_out_valid;
    abort         = in_txn && !dut_out_valid && (wd_cnt_q == WdLast);
    epoch_next    = epoch_cnt_q + 32'd1;
    auto_roll     = auto_mode && (epoch_next >= EpochLen);
    err_trig      = abort || (in_txn && sel_col);
  end

  always_comb begin
    state_d        = state_q;
    active_sel_d   = active_sel_q;
    sw_auto_d      = sw_auto_q;
    sw_sel_d       = sw_sel_q;
    dut_data_d     = dut_data_q;
    dut_start_d    = 1'b0;
    wd_cnt_d       = wd_cnt_q;
    epoch_cnt_d    = epoch_cnt_q;
    txn_count_d    = txn_count_q;
    alarm_hang_d   = alarm_hang_q;
    err_valid_d    = err_valid_q;
    error_input_d  = error_input_q;
    error_output_d = error_output_q;

    unique case (state_q)
      StIdle: begin
        if (idle_sw) begin
          state_d   = StSwitch;
          sw_auto_d = auto_mode;
          sw_sel_d  = sel_req;
        end else if (idle_ok && sel_start) begin
          state_d     = StBusy;
          dut_start_d = 1'b1;
          dut_data_d  = sel_data;
          wd_cnt_d    = '0;
        end
      end
      StBusy, StDrain: begin
        wd_cnt_d = wd_cnt_q + 32'd1;
        if (done) begin
          txn_count_d = txn_count_q + 32'd1;
          epoch_cnt_d = epoch_next;
        end
        if (abort) begin
          alarm_hang_d = 1'b1;
        end
        if (state_q == StDrain) begin
          if (done || abort) begin
            state_d = StSwitch;
          end
        end else if (done && auto_roll) begin
          state_d   = StSwitch;
          sw_auto_d = 1'b1;
        end else if (manual_req) begin
          state_d   = (done || abort) ? StSwitch : StDrain;
          sw_auto_d = 1'b0;
          sw_sel_d  = sel_req;
        end else if (done || abort) begin
          state_d = StIdle;
        end
      end
      StSwitch: begin
        if (sw_auto_q) begin
          active_sel_d = (active_sel_q == LastSel) ? '0 : active_sel_q + SEL_W'(1);
        end else begin
          active_sel_d = sw_sel_q;
        end
        epoch_cnt_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear wins over a trigger landing in the same cycle.
    if (err_clr) begin
      err_valid_d    = 1'b0;
      error_input_d  = '0;
      error_output_d = '0;
    end else if (err_trig && !err_valid_q) begin
      err_valid_d    = 1'b1;
      error_input_d  = dut_data_q;
      error_output_d = abort ? '0 : dut_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      active_sel_q   <= '0;
      sw_auto_q      <= 1'b0;
      sw_sel_q       <= '0;
      dut_data_q     <= '0;
      dut_start_q    <= 1'b0;
      wd_cnt_q       <= '0;
      epoch_cnt_q    <= '0;
      txn_count_q    <= '0;
      alarm_hang_q   <= 1'b0;
      err_valid_q    <= 1'b0;
      error_input_q  <= '0;
      error_output_q <= '0;
    end else begin
      state_q        <= state_d;
      active_sel_q   <= active_sel_d;
      sw_auto_q      <= sw_auto_d;
      sw_sel_q       <= sw_sel_d;
      dut_data_q     <= dut_data_d;
      dut_start_q    <= dut_start_d;
      wd_cnt_q       <= wd_cnt_d;
      epoch_cnt_q    <= epoch_cnt_d;
      txn_count_q    <= txn_count_d;
      alarm_hang_q   <= alarm_hang_d;
      err_valid_q    <= err_valid_d;
      error_input_q  <= error_input_d;
      error_output_q <= error_output_d;
    end
  end

  assign src_ready       = idle_ok ? act_onehot : '0;
  assign src_valid       = done ? act_onehot : '0;
  assign dut_data        = dut_data_q;
  assign dut_start       = dut_start_q;
  assign res_data        = dut_out;
  assign active_sel      = active_sel_q;
  assign alarm_hang      = alarm_hang_q;
  assign alarm_collision = sel_col;
  assign coverage_score  = sel_cov;
  assign txn_count       = txn_count_q;
  assign err_valid       = err_valid_q;
  assign error_input     = error_input_q;
  assign error_output    = error_output_q;

endmodule

// File: tb/tb_fuzz_harness_sched.sv
// Directed bench for fuzz_harness_sched with small widths, EPOCH_LEN 4, WATCHDOG_LIMIT 8.
module tb_fuzz_harness_sched;

  localparam int unsigned IW = 16;
  localparam int unsigned OW = 8;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           auto_mode;
  logic [SW-1:0]  sel_req;
  logic           err_clr;
  logic [NS*IW-1:0] src_data;
  logic [NS-1:0]  src_start;
  logic [NS-1:0]  src_col;
  logic [NS*8-1:0] src_cov;
  logic [NS-1:0]  src_ready;
  logic [NS-1:0]  src_valid;
  logic [IW-1:0]  dut_data;
  logic           dut_start;
  logic           dut_ready;
  logic [OW-1:0]  dut_out;
  logic           dut_out_valid;
  logic [OW-1:0]  res_data;
  logic [SW-1:0]  active_sel;
  logic           alarm_hang;
  logic           alarm_collision;
  logic [7:0]     coverage_score;
  logic [31:0]    txn_count;
  logic           err_valid;
  logic [IW-1:0]  error_input;
  logic [OW-1:0]  error_output;

  int n_checks = 0;
  int n_fail   = 0;

  fuzz_harness_sched #(
    .INPUT_WIDTH   (IW),
    .OUTPUT_WIDTH  (OW),
    .NUM_SRC       (NS),
    .EPOCH_LEN     (4),
    .WATCHDOG_LIMIT(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .auto_mode      (auto_mode),
    .sel_req        (sel_req),
    .err_clr        (err_clr),
    .src_data       (src_data),
    .src_start      (src_start),
    .src_col        (src_col),
    .src_cov        (src_cov),
    .src_ready      (src_ready),
    .src_valid      (src_valid),
    .dut_data       (dut_data),
    .dut_start      (dut_start),
    .dut_ready      (dut_ready),
    .dut_out        (dut_out),
    .dut_out_valid  (dut_out_valid),
    .res_data       (res_data),
    .active_sel     (active_sel),
    .alarm_hang     (alarm_hang),
    .alarm_collision(alarm_collision),
    .coverage_score (coverage_score),
    .txn_count      (txn_count),
    .err_valid      (err_valid),
    .error_input    (error_input),
    .error_output   (error_output)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    auto_mode     = 1'b0;
    sel_req       = '0;
    err_clr       = 1'b0;
    src_data      = {16'h3333, 16'h2222, 16'hA5A5};
    src_start     = '0;
    src_col       = '0;
    src_cov       = {8'h30, 8'h20, 8'h10};
    dut_ready     = 1'b0;
    dut_out       = '0;
    dut_out_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_active_sel", 64'(active_sel), 64'd0);
    check_eq("rst_txn_count", 64'(txn_count), 64'd0);
    check_eq("rst_dut_start", 64'(dut_start), 64'd0);
    check_eq("rst_dut_data", 64'(dut_data), 64'd0);
    check_eq("rst_alarm_hang", 64'(alarm_hang), 64'd0);
    check_eq("rst_err_valid", 64'(err_valid), 64'd0);
    check_eq("rst_src_ready", 64'(src_ready), 64'd0);
    check_eq("rst_cov", 64'(coverage_score), 64'h10);

    // Basic manual transaction on source 0
    dut_ready = 1'b1;
    #1;
    check_eq("idle_ready", 64'(src_ready), 64'b001);
    src_start = 3'b001;
    tick();
    src_start = '0;
    check_eq("t1_dut_start", 64'(dut_start), 64'd1);
    check_eq("t1_dut_data", 64'(dut_data), 64'hA5A5);
    check_eq("t1_busy_ready", 64'(src_ready), 64'd0);
    tick();
    check_eq("t1_start_pulse", 64'(dut_start), 64'd0);
    repeat (3) tick();
    dut_out_valid = 1'b1;
    dut_out       = 8'h5C;
    #1;
    check_eq("t1_src_valid", 64'(src_valid), 64'b001);
    check_eq("t1_res_data", 64'(res_data), 64'h5C);
    tick();
    dut_out_valid = 1'b0;
    check_eq("t1_txn_count", 64'(txn_count), 64'd1);
    check_eq("t1_idle_ready", 64'(src_ready), 64'b001);

    // Switch request during BUSY goes through DRAIN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    src_start = 3'b001;
    tick();
    src_start = '0;
    sel_req   = 2'd2;
    tick();
    src_start = 3'b100;
    tick();
    check_eq("drain_dut_start", 64'(dut_start), 64'd0);
    check_eq("drain_ready", 64'(src_ready), 64'd0);
    dut_out_valid = 1'b1;
    dut_out       = 8'h42;
    #1;
    check_eq("drain_src_valid", 64'(src_valid), 64'b001);
    tick();
    dut_out_valid = 1'b0;
    check_eq("switch_ready", 64'(src_ready), 64'd0);
    check_eq("switch_sel_old", 64'(active_sel), 64'd0);
    tick();
    check_eq("drain_new_sel", 64'(active_sel), 64'd2);
    check_eq("drain_new_ready", 64'(src_ready), 64'b100);
    check_eq("drain_no_accept", 64'(dut_data), 64'hA5A5);
    check_eq("drain_txn_count", 64'(txn_count), 64'd1);
    src_start = '0;

    // Out-of-range select is ignored
    sel_req = 2'd3;
    #1;
    check_eq("sel3_ready", 64'(src_ready), 64'b100);
    tick();
    check_eq("sel3_active", 64'(active_sel), 64'd2);
    sel_req = 2'd2;

    // Watchdog abort on source 2
    dut_out   = 8'hEE;
    src_start = 3'b100;
    tick();
    src_start = '0;
    repeat (7) tick();
    check_eq("wd_pre_hang", 64'(alarm_hang), 64'd0);
    tick();
    check_eq("wd_hang", 64'(alarm_hang), 64'd1);
    check_eq("wd_err_valid", 64'(err_valid), 64'd1);
    check_eq("wd_err_out", 64'(error_output), 64'd0);
    check_eq("wd_err_in", 64'(error_input), 64'h3333);
    check_eq("wd_txn_count", 64'(txn_count), 64'd1);
    check_eq("wd_idle_ready", 64'(src_ready), 64'b100);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("clr_err_valid", 64'(err_valid), 64'd0);
    check_eq("hang_sticky", 64'(alarm_hang), 64'd1);

    // Collision capture on source 1
    sel_req = 2'd1;
    tick();
    tick();
    check_eq("sel1_active", 64'(active_sel), 64'd1);
    check_eq("sel1_cov", 64'(coverage_score), 64'h20);
    src_start = 3'b010;
    tick();
    src_start = '0;
    dut_out   = 8'h77;
    src_col   = 3'b010;
    #1;
    check_eq("col_alarm", 64'(alarm_collision), 64'd1);
    tick();
    src_col = '0;
    check_eq("col_err_valid", 64'(err_valid), 64'd1);
    check_eq("col_err_out", 64'(error_output), 64'h77);
    check_eq("col_err_in", 64'(error_input), 64'h2222);
    dut_out = 8'h99;
    src_col = 3'b010;
    tick();
    src_col = '0;
    check_eq("col2_ignored", 64'(error_output), 64'h77);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("col_clr", 64'(err_valid), 64'd0);
    src_col = 3'b100;
    #1;
    check_eq("col_other_alarm", 64'(alarm_collision), 64'd0);
    tick();
    src_col = '0;
    check_eq("col_other_nocap", 64'(err_valid), 64'd0);
    dut_out_valid = 1'b1;
    dut_out       = 8'h11;
    #1;
    check_eq("col_src_valid", 64'(src_valid), 64'b010);
    tick();
    check_eq("col_txn_count", 64'(txn_count), 64'd2);

    // Result valid while idle is ignored
    #1;
    check_eq("idle_valid_ignored", 64'(src_valid), 64'd0);
    tick();
    dut_out_valid = 1'b0;
    check_eq("idle_valid_nocount", 64'(txn_count), 64'd2);

    // Reset while draining
    src_start = 3'b010;
    tick();
    src_start = '0;
    sel_req   = 2'd0;
    tick();
    src_col = 3'b010;
    tick();
    src_col = '0;
    check_eq("pre_rst_err", 64'(err_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rd_active_sel", 64'(active_sel), 64'd0);
    check_eq("rd_alarm_hang", 64'(alarm_hang), 64'd0);
    check_eq("rd_err_valid", 64'(err_valid), 64'd0);
    check_eq("rd_err_in", 64'(error_input), 64'd0);
    check_eq("rd_txn_count", 64'(txn_count), 64'd0);
    check_eq("rd_dut_data", 64'(dut_data), 64'd0);
    check_eq("rd_dut_start", 64'(dut_start), 64'd0);
    check_eq("rd_idle_ready", 64'(src_ready), 64'b001);

    // Auto round-robin with continuous starts
    auto_mode = 1'b1;
    src_start = 3'b111;
    for (int i = 0; i < 12; i++) begin
      check_eq($sformatf("auto_sel_%0d", i), 64'(active_sel), 64'((i / 4) % 3));
      tick();
      tick();
      dut_out_valid = 1'b1;
      dut_out       = 8'(i);
      tick();
      dut_out_valid = 1'b0;
      if ((i % 4) == 3) begin
        check_eq($sformatf("auto_sw_ready_%0d", i), 64'(src_ready), 64'd0);
        tick();
      end
    end
    check_eq("auto_wrap_sel", 64'(active_sel), 64'd0);
    check_eq("auto_txn_count", 64'(txn_count), 64'd12);
    src_start = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
